// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word and request-unit FSM state encoding.
package cpu_types_pkg;

    localparam int unsigned WORD_W_DEFAULT = 32;

    typedef logic [WORD_W_DEFAULT-1:0] word_t;

    typedef enum logic [1:0] {
        REQ_FETCH = 2'd0,
        REQ_DATA  = 2'd1,
        REQ_HALT  = 2'd2
    } req_state_t;

endpackage

// File: rtl/request_unit_stall_counter.sv
// Saturating stall counter (req_stall_counter) with enable and synchronous clear,
// used by request_unit when REQ_STATS_EN is defined.
module req_stall_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/request_unit.sv
// Cache request sequencer: fetch / data-access / halt FSM driving iREN, dREN, dWEN.
// Optional stall statistics ports are enabled by defining REQ_STATS_EN.
module request_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              MemToReg,
    input  logic              MemWrite,
    input  logic              halt_in,
    input  logic              ihit,
    input  logic              dhit,
    input  logic [WORD_W-1:0] daddr_in,
    input  logic [WORD_W-1:0] dstore_in,
    input  logic [WORD_W-1:0] dload_in,
    output logic              iREN,
    output logic              dREN,
    output logic              dWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic [WORD_W-1:0] dload_q,
    output logic              load_wen,
    output logic              pc_en,
    output logic              halt_out
`ifdef REQ_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0] istall_cnt,
    output logic [STALL_CNT_W-1:0] dstall_cnt
`endif
);

    req_state_t state;

    assign iREN     = (state == REQ_FETCH);
    assign halt_out = (state == REQ_HALT);

    // PC advances on the completing handshake of each instruction, never on halt.
    always_comb begin
        pc_en = 1'b0;
        case (state)
            REQ_FETCH: pc_en = ihit & ~halt_in & ~(MemToReg | MemWrite);
            REQ_DATA:  pc_en = dhit;
            default:   pc_en = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= REQ_FETCH;
            dREN      <= 1'b0;
            dWEN      <= 1'b0;
            dmemaddr  <= '0;
            dmemstore <= '0;
            dload_q   <= '0;
            load_wen  <= 1'b0;
        end else begin
            load_wen <= 1'b0;
            case (state)
                REQ_FETCH: begin
                    if (ihit) begin
                        if (halt_in) begin
                            state <= REQ_HALT;
                        end else if (MemToReg | MemWrite) begin
                            state     <= REQ_DATA;
                            dmemaddr  <= daddr_in;
                            dmemstore <= dstore_in;
                            dWEN      <= MemWrite;
                            dREN      <= MemToReg & ~MemWrite;
                        end
                    end
                end
                REQ_DATA: begin
                    if (dhit) begin
                        if (dREN) begin
                            dload_q  <= dload_in;
                            load_wen <= 1'b1;
                        end
                        dREN  <= 1'b0;
                        dWEN  <= 1'b0;
                        state <= REQ_FETCH;
                    end
                end
                REQ_HALT: begin
                    state <= REQ_HALT;
                end
                default: begin
                    state <= REQ_FETCH;
                end
            endcase
        end
    end

`ifdef REQ_STATS_EN
    req_stall_counter #(.W(STALL_CNT_W)) u_istall (
        .clk   (CLK),
        .rst   (RST),
        .clr   (1'b0),
        .en    ((state == REQ_FETCH) & ~ihit),
        .count (istall_cnt)
    );

    req_stall_counter #(.W(STALL_CNT_W)) u_dstall (
        .clk   (CLK),
        .rst   (RST),
        .clr   (1'b0),
        .en    ((state == REQ_DATA) & ~dhit),
        .count (dstall_cnt)
    );
`endif

endmodule

// File: tb/tb_request_unit.sv
// Self-checking bench for request_unit: directed scenarios plus randomized
// instruction streams checked against a transaction-level expectation model.
module tb_request_unit;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned STALL_CNT_W = 16;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              MemToReg = 1'b0, MemWrite = 1'b0, halt_in = 1'b0;
    logic              ihit = 1'b0, dhit = 1'b0;
    logic [WORD_W-1:0] daddr_in = '0, dstore_in = '0, dload_in = '0;
    logic              iREN, dREN, dWEN, load_wen, pc_en, halt_out;
    logic [WORD_W-1:0] dmemaddr, dmemstore, dload_q;
`ifdef REQ_STATS_EN
    logic [STALL_CNT_W-1:0] istall_cnt, dstall_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    request_unit #(.WORD_W(WORD_W), .STALL_CNT_W(STALL_CNT_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .MemToReg  (MemToReg),
        .MemWrite  (MemWrite),
        .halt_in   (halt_in),
        .ihit      (ihit),
        .dhit      (dhit),
        .daddr_in  (daddr_in),
        .dstore_in (dstore_in),
        .dload_in  (dload_in),
        .iREN      (iREN),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .dmemaddr  (dmemaddr),
        .dmemstore (dmemstore),
        .dload_q   (dload_q),
        .load_wen  (load_wen),
        .pc_en     (pc_en),
        .halt_out  (halt_out)
`ifdef REQ_STATS_EN
        ,
        .istall_cnt(istall_cnt),
        .dstall_cnt(dstall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // One cycle: inputs change on the falling edge, outputs are sampled 1ns later.
    task automatic drive(input logic ih, input logic mr, input logic mw, input logic hl,
                         input logic dh, input logic [WORD_W-1:0] a,
                         input logic [WORD_W-1:0] s, input logic [WORD_W-1:0] l);
        @(negedge CLK);
        ihit = ih; MemToReg = mr; MemWrite = mw; halt_in = hl; dhit = dh;
        daddr_in = a; dstore_in = s; dload_in = l;
        #1;
    endtask

    task automatic apply_reset;
        @(negedge CLK);
        ihit = 0; MemToReg = 0; MemWrite = 0; halt_in = 0; dhit = 0;
        RST = 1'b1;
        @(negedge CLK);
        @(posedge CLK);
        #2 RST = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        compared++;
        if ({dREN, dWEN, load_wen, pc_en, halt_out} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl got %b exp 00000", {dREN, dWEN, load_wen, pc_en, halt_out});
        end
        compared++;
        if ({dmemaddr, dmemstore, dload_q} !== '0) begin
            mismatched++;
            $display("FAIL reset_regs got %h/%h/%h exp 0", dmemaddr, dmemstore, dload_q);
        end
        @(posedge CLK);
        #2 RST = 1'b0;
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        compared++;
        if (iREN !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_iren got %b exp 1", iREN);
        end
    endtask

    task automatic test_alu;
        drive(1, 0, 0, 0, 0, 32'h1234, '0, '0);
        compared++;
        if ({iREN, dREN, dWEN, pc_en} !== 4'b1001) begin
            mismatched++;
            $display("FAIL alu_cycle got %b exp 1001", {iREN, dREN, dWEN, pc_en});
        end
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        compared++;
        if ({iREN, dREN, dWEN, pc_en} !== 4'b1000) begin
            mismatched++;
            $display("FAIL alu_after got %b exp 1000", {iREN, dREN, dWEN, pc_en});
        end
    endtask

    task automatic test_load;
        drive(1, 1, 0, 0, 0, 32'h100, 32'h77, '0);
        compared++;
        if ({iREN, pc_en} !== 2'b10) begin
            mismatched++;
            $display("FAIL load_issue got %b exp 10", {iREN, pc_en});
        end
        for (int k = 0; k < 3; k++) begin
            drive($urandom_range(0, 1), 0, 0, 0, (k == 2), $urandom, $urandom, 32'hDEADBEEF);
            compared++;
            if ({iREN, dREN, dWEN, pc_en, load_wen} !== {3'b010, (k == 2), 1'b0}) begin
                mismatched++;
                $display("FAIL load_wait%0d got %b exp %b", k, {iREN, dREN, dWEN, pc_en, load_wen},
                         {3'b010, (k == 2), 1'b0});
            end
            compared++;
            if (dmemaddr !== 32'h100) begin
                mismatched++;
                $display("FAIL load_addr%0d got %h exp 00000100", k, dmemaddr);
            end
        end
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        compared++;
        if ({iREN, dREN, load_wen, pc_en} !== 4'b1010 || dload_q !== 32'hDEADBEEF) begin
            mismatched++;
            $display("FAIL load_done got %b/%h exp 1010/deadbeef", {iREN, dREN, load_wen, pc_en}, dload_q);
        end
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        compared++;
        if (load_wen !== 1'b0) begin
            mismatched++;
            $display("FAIL load_wen_pulse got %b exp 0", load_wen);
        end
    endtask

    task automatic test_store;
        drive(1, 0, 1, 0, 0, 32'h200, 32'h55, '0);
        compared++;
        if (pc_en !== 1'b0) begin
            mismatched++;
            $display("FAIL store_issue pc_en got %b exp 0", pc_en);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 0, 0, (k == 3), $urandom, $urandom, $urandom);
            compared++;
            if ({dWEN, dREN, iREN, pc_en, load_wen} !== {3'b100, (k == 3), 1'b0} ||
                dmemaddr !== 32'h200 || dmemstore !== 32'h55) begin
                mismatched++;
                $display("FAIL store_hold%0d got %b %h %h exp %b 00000200 00000055", k,
                         {dWEN, dREN, iREN, pc_en, load_wen}, dmemaddr, dmemstore,
                         {3'b100, (k == 3), 1'b0});
            end
        end
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        compared++;
        if ({dWEN, load_wen, iREN} !== 3'b001 || dload_q !== 32'hDEADBEEF) begin
            mismatched++;
            $display("FAIL store_done got %b/%h exp 001/deadbeef", {dWEN, load_wen, iREN}, dload_q);
        end
    endtask

    task automatic test_halt;
        drive(1, 0, 1, 1, 0, 32'h300, 32'h9, '0);
        compared++;
        if (pc_en !== 1'b0) begin
            mismatched++;
            $display("FAIL halt_issue pc_en got %b exp 0", pc_en);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1, $urandom_range(0, 1), $urandom_range(0, 1), 0, 1, $urandom, $urandom, $urandom);
            compared++;
            if ({halt_out, iREN, dREN, dWEN, pc_en, load_wen} !== 6'b100000) begin
                mismatched++;
                $display("FAIL halt_hold%0d got %b exp 100000", k,
                         {halt_out, iREN, dREN, dWEN, pc_en, load_wen});
            end
        end
    endtask

    task automatic test_reset_mid_load;
        apply_reset();
        drive(1, 1, 0, 0, 0, 32'h400, '0, '0);
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        compared++;
        if (dREN !== 1'b1) begin
            mismatched++;
            $display("FAIL rml_pre dREN got %b exp 1", dREN);
        end
        #1 RST = 1'b1;
        #1;
        compared++;
        if ({dREN, dWEN, pc_en, load_wen} !== 4'b0000) begin
            mismatched++;
            $display("FAIL rml_async got %b exp 0000", {dREN, dWEN, pc_en, load_wen});
        end
        @(posedge CLK);
        #2 RST = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 0, 1, '0, '0, 32'hAAAA5555);
            compared++;
            if ({iREN, dREN, pc_en, load_wen, halt_out} !== 5'b10000 || dload_q !== '0) begin
                mismatched++;
                $display("FAIL rml_after%0d got %b/%h exp 10000/0", k,
                         {iREN, dREN, pc_en, load_wen, halt_out}, dload_q);
            end
        end
    endtask

    // Random instruction stream: each instruction is (fetch stalls, kind, data wait).
    task automatic test_random;
        logic [WORD_W-1:0] exp_q, a, s, l;
        logic              exp_lw;
        int                kind, si, dw;
        int                exp_is, exp_ds;
        logic [5:0]        exp_v;
        apply_reset();
        exp_q = '0; exp_lw = 1'b0; exp_is = 0; exp_ds = 0;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            si   = $urandom_range(0, 2);
            dw   = $urandom_range(0, 3);
            a = $urandom; s = $urandom; l = $urandom;
            for (int c = 0; c < si; c++) begin
                drive(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom_range(0, 1), $urandom, $urandom, $urandom);
                exp_v = {1'b1, 2'b00, 1'b0, exp_lw, 1'b0};
                exp_lw = 1'b0;
                exp_is++;
                compared++;
                if ({iREN, dREN, dWEN, pc_en, load_wen, halt_out} !== exp_v || dload_q !== exp_q) begin
                    mismatched++;
                    $display("FAIL rnd_stall n%0d got %b/%h exp %b/%h", n,
                             {iREN, dREN, dWEN, pc_en, load_wen, halt_out}, dload_q, exp_v, exp_q);
                end
            end
            drive(1, (kind == 1) || ((kind == 2) && ($urandom_range(0, 1) == 1)), (kind == 2), 0,
                  $urandom_range(0, 1), a, s, $urandom);
            exp_v = {1'b1, 2'b00, (kind == 0), exp_lw, 1'b0};
            exp_lw = 1'b0;
            compared++;
            if ({iREN, dREN, dWEN, pc_en, load_wen, halt_out} !== exp_v || dload_q !== exp_q) begin
                mismatched++;
                $display("FAIL rnd_issue n%0d got %b/%h exp %b/%h", n,
                         {iREN, dREN, dWEN, pc_en, load_wen, halt_out}, dload_q, exp_v, exp_q);
            end
            if (kind != 0) begin
                for (int c = 0; c <= dw; c++) begin
                    drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0,
                          (c == dw), $urandom, $urandom, l);
                    exp_v = {1'b0, (kind == 1), (kind == 2), (c == dw), 2'b00};
                    if (c != dw) exp_ds++;
                    compared++;
                    if ({iREN, dREN, dWEN, pc_en, load_wen, halt_out} !== exp_v ||
                        dmemaddr !== a || dmemstore !== s) begin
                        mismatched++;
                        $display("FAIL rnd_data n%0d got %b %h %h exp %b %h %h", n,
                                 {iREN, dREN, dWEN, pc_en, load_wen, halt_out}, dmemaddr, dmemstore,
                                 exp_v, a, s);
                    end
                end
                if (kind == 1) begin
                    exp_q  = l;
                    exp_lw = 1'b1;
                end
            end
        end
`ifdef REQ_STATS_EN
        drive(1, 0, 0, 0, 0, '0, '0, '0);
        compared++;
        if (istall_cnt !== STALL_CNT_W'(exp_is) || dstall_cnt !== STALL_CNT_W'(exp_ds)) begin
            mismatched++;
            $display("FAIL rnd_stats got %0d/%0d exp %0d/%0d", istall_cnt, dstall_cnt, exp_is, exp_ds);
        end
`endif
    endtask

`ifdef REQ_STATS_EN
    task automatic test_stats;
        apply_reset();
        for (int k = 0; k < 4; k++) drive(0, 0, 0, 0, 0, '0, '0, '0);
        drive(1, 1, 0, 0, 0, 32'h500, '0, '0);
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        drive(0, 0, 0, 0, 1, '0, '0, 32'h1);
        drive(1, 0, 0, 0, 0, '0, '0, '0);
        compared++;
        if (istall_cnt !== 16'd4 || dstall_cnt !== 16'd2) begin
            mismatched++;
            $display("FAIL stats_cnt got %0d/%0d exp 4/2", istall_cnt, dstall_cnt);
        end
        drive(1, 0, 0, 1, 0, '0, '0, '0);
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 0, '0, '0, '0);
        compared++;
        if (istall_cnt !== 16'd4 || dstall_cnt !== 16'd2) begin
            mismatched++;
            $display("FAIL stats_halt_freeze got %0d/%0d exp 4/2", istall_cnt, dstall_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_halt();
        test_reset_mid_load();
        test_random();
`ifdef REQ_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
